// File: rtl/pwm_pkg.sv
// Shared definitions for the multichannel PWM driver: default widths,
// counter-mode enumeration and the duty-cycle compare used by every channel.
// Optional build macro: PWM_CENTER_ALIGNED_EN (triangle counter, see top).
package pwm_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    // Operand width of is_on; counter/level widths up to this are supported.
    localparam int CMP_W = 32;

    typedef enum logic {SAW, TRIANGLE} cnt_mode_e;

    // Output is high while the period counter is below the level, so level 0
    // never fires and any level above the top value is permanently on.
    function automatic logic is_on(input logic [CMP_W-1:0] level,
                                   input logic [CMP_W-1:0] cnt);
        return cnt < level;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty level and a registered compare
// against the shared period counter.
// Optional build macro: PWM_CENTER_ALIGNED_EN (no effect inside the channel).
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             load,
    input  logic [WIDTH-1:0] cnt,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow_level;
    logic [WIDTH-1:0] active_level;

    // Shadow takes writes any time; active only changes at a period boundary,
    // and a write landing on that boundary goes straight into the new period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_level <= '0;
            active_level <= '0;
            pwm          <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow_level <= wr_data;
            end
            if (load) begin
                active_level <= wr_en ? wr_data : shadow_level;
            end
            pwm <= is_on(CMP_W'(active_level), CMP_W'(cnt));
        end
    end

endmodule

// File: rtl/pwm_multichannel_driver.sv
// N-channel PWM generator with prescaler and programmable period top.
// Level and top writes are double-buffered and applied at the period boundary.
// Optional build macro: PWM_CENTER_ALIGNED_EN selects a triangle (up/down)
// counter for centre-aligned pulses; default build uses a sawtooth counter.
module pwm_multichannel_driver
    import pwm_pkg::*;
#(
    parameter  int CHANNELS   = 8,
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int PRESCALE_W = DEF_PRESCALE_W,
    localparam int ADDR_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  lvl_wr_en,
    input  logic [ADDR_W-1:0]     lvl_wr_addr,
    input  logic [WIDTH-1:0]      lvl_wr_data,
    input  logic                  top_wr_en,
    input  logic [WIDTH-1:0]      top_wr_data,
    output logic [CHANNELS-1:0]   pwm_out,
    output logic                  period_start
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;
    logic [WIDTH-1:0]      cnt;
    logic [WIDTH-1:0]      shadow_top;
    logic [WIDTH-1:0]      active_top;
    logic                  boundary;
    logic [CHANNELS-1:0]   lvl_sel;

    // prescale is sampled live; lowering it below pre_cnt lets pre_cnt wrap.
    assign tick = (pre_cnt == prescale);

    // Free-running prescaler that restarts on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRESCALE_W'(1);
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_down;
    logic going_down;

    // Reaching the top on the way up turns the counter around on the same tick.
    assign going_down = dir_down || (cnt == active_top);
    assign boundary   = tick && ((active_top == '0) ||
                                 (going_down && (cnt == WIDTH'(1))));

    // Triangle counter 0..top..0; a zero top pins it at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (tick) begin
            if (active_top == '0) begin
                cnt      <= '0;
                dir_down <= 1'b0;
            end else if (going_down) begin
                cnt      <= cnt - WIDTH'(1);
                dir_down <= (cnt != WIDTH'(1));
            end else begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end
`else
    assign boundary = tick && (cnt == active_top);

    // Sawtooth counter 0..top, period of top+1 ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= (cnt == active_top) ? '0 : cnt + WIDTH'(1);
        end
    end
`endif

    // Double-buffered period top with boundary bypass, plus the boundary pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_top   <= '1;
            active_top   <= '1;
            period_start <= 1'b0;
        end else begin
            if (top_wr_en) begin
                shadow_top <= top_wr_data;
            end
            if (boundary) begin
                active_top <= top_wr_en ? top_wr_data : shadow_top;
            end
            period_start <= boundary;
        end
    end

    // Addresses at or above CHANNELS select no channel, so such writes vanish.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign lvl_sel[g] = lvl_wr_en && (lvl_wr_addr == ADDR_W'(g));

        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (lvl_sel[g]),
            .wr_data (lvl_wr_data),
            .load    (boundary),
            .cnt     (cnt),
            .pwm     (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_multichannel_driver.sv
// Self-checking bench for pwm_multichannel_driver (sawtooth build),
// CHANNELS=6, WIDTH=4, PRESCALE_W=4.
module tb_pwm_multichannel_driver;

    localparam int CH = 6;
    localparam int W  = 4;
    localparam int PW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] prescale = '0;
    logic          lvl_wr_en = 1'b0;
    logic [AW-1:0] lvl_wr_addr = '0;
    logic [W-1:0]  lvl_wr_data = '0;
    logic          top_wr_en = 1'b0;
    logic [W-1:0]  top_wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_multichannel_driver #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .PRESCALE_W (PW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale),
        .lvl_wr_en    (lvl_wr_en),
        .lvl_wr_addr  (lvl_wr_addr),
        .lvl_wr_data  (lvl_wr_data),
        .top_wr_en    (top_wr_en),
        .top_wr_data  (top_wr_data),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    // Reference model: prescaler/period/duty rules as plain arithmetic.
    int      m_pre, m_cnt, m_top_sh, m_top_act;
    int      m_lsh [CH];
    int      m_lact [CH];
    logic [CH-1:0] m_out;
    logic    m_ps;
    logic    m_tick, m_bnd;

    assign m_tick = (m_pre == int'(prescale));
    assign m_bnd  = m_tick && (m_cnt == m_top_act);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pre <= 0; m_cnt <= 0; m_top_sh <= 15; m_top_act <= 15;
            m_out <= '0; m_ps <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_lsh[i]  <= 0;
                m_lact[i] <= 0;
            end
        end else begin
            m_pre <= m_tick ? 0 : (m_pre + 1) % 16;
            if (m_tick) m_cnt <= m_bnd ? 0 : m_cnt + 1;
            m_ps <= m_bnd;
            for (int i = 0; i < CH; i++) begin
                m_out[i] <= (m_cnt < m_lact[i]);
                if (lvl_wr_en && int'(lvl_wr_addr) == i) m_lsh[i] <= int'(lvl_wr_data);
                if (m_bnd)
                    m_lact[i] <= (lvl_wr_en && int'(lvl_wr_addr) == i) ? int'(lvl_wr_data) : m_lsh[i];
            end
            if (top_wr_en) m_top_sh <= int'(top_wr_data);
            if (m_bnd) m_top_act <= top_wr_en ? int'(top_wr_data) : m_top_sh;
        end
    end

    // Drive one cycle of inputs from a negedge, ending on the next negedge.
    task automatic step(input logic le, input logic [AW-1:0] la, input logic [W-1:0] ld,
                        input logic te, input logic [W-1:0] td);
        lvl_wr_en = le; lvl_wr_addr = la; lvl_wr_data = ld;
        top_wr_en = te; top_wr_data = td;
        @(negedge clk);
        lvl_wr_en = 1'b0;
        top_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Steps until period_start is seen; n = -1 if the bound expires.
    task automatic wait_ps(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            if (period_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (pwm_out !== 6'h00) begin
            n_fail++; $display("FAIL reset_pwm_out actual=%h expected=00", pwm_out);
        end
        n_cmp++;
        if (period_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_period_start actual=%b expected=0", period_start);
        end
        rst = 1'b0;
        wait_ps(40, n);
        n_cmp++;
        if (n !== 16) begin
            n_fail++; $display("FAIL first_period_start clocks=%0d expected=16", n);
        end
    endtask

    task automatic test_level_wrap();
        int n, hi;
        logic early;
        logic [CH-1:0] other;
        idle(7);
        step(1'b1, 3'd2, 4'd4, 1'b0, '0);
        early = 1'b0;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            early |= pwm_out[2];
            if (period_start === 1'b1) begin
                n = i;
                break;
            end
        end
        n_cmp++;
        if (n !== 8) begin
            n_fail++; $display("FAIL wrap_after_write clocks=%0d expected=8", n);
        end
        n_cmp++;
        if (early !== 1'b0) begin
            n_fail++; $display("FAIL ch2_before_wrap actual=%b expected=0", early);
        end
        hi = 0;
        other = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            hi += int'(pwm_out[2]);
            other |= pwm_out & 6'b111011;
        end
        n_cmp++;
        if (hi !== 4) begin
            n_fail++; $display("FAIL ch2_high_clocks actual=%0d expected=4", hi);
        end
        n_cmp++;
        if (other !== '0) begin
            n_fail++; $display("FAIL other_channels_idle actual=%h expected=00", other);
        end
    endtask

    task automatic test_top_period();
        int n, len, c0, c1, c3;
        step(1'b0, '0, '0, 1'b1, 4'd9);
        step(1'b1, 3'd0, 4'd12, 1'b0, '0);
        step(1'b1, 3'd1, 4'd0, 1'b0, '0);
        step(1'b1, 3'd3, 4'd9, 1'b0, '0);
        wait_ps(40, n);
        n_cmp++;
        if (n < 0) begin
            n_fail++; $display("FAIL top_boundary_timeout clocks=%0d expected<=40", n);
        end
        len = -1; c0 = 0; c1 = 0; c3 = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]); c3 += int'(pwm_out[3]);
            if (period_start === 1'b1) begin
                len = i;
                break;
            end
        end
        n_cmp++;
        if (len !== 10) begin
            n_fail++; $display("FAIL top9_period actual=%0d expected=10", len);
        end
        n_cmp++;
        if (c0 !== 10) begin
            n_fail++; $display("FAIL ch0_over_top actual=%0d expected=10", c0);
        end
        n_cmp++;
        if (c1 !== 0) begin
            n_fail++; $display("FAIL ch1_zero actual=%0d expected=0", c1);
        end
        n_cmp++;
        if (c3 !== 9) begin
            n_fail++; $display("FAIL ch3_level9 actual=%0d expected=9", c3);
        end
    endtask

    task automatic test_prescale();
        int n, len, c5;
        prescale = 4'd2;
        step(1'b0, '0, '0, 1'b1, 4'd15);
        step(1'b1, 3'd5, 4'd8, 1'b0, '0);
        wait_ps(200, n);
        n_cmp++;
        if (n < 0) begin
            n_fail++; $display("FAIL prescale_boundary_timeout clocks=%0d expected<=200", n);
        end
        len = -1; c5 = 0;
        for (int i = 1; i <= 200; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            c5 += int'(pwm_out[5]);
            if (i == 1) begin
                n_cmp++;
                if (period_start !== 1'b0) begin
                    n_fail++; $display("FAIL period_start_width actual=%b expected=0", period_start);
                end
            end
            if (period_start === 1'b1) begin
                len = i;
                break;
            end
        end
        n_cmp++;
        if (len !== 48) begin
            n_fail++; $display("FAIL prescale_period actual=%0d expected=48", len);
        end
        n_cmp++;
        if (c5 !== 24) begin
            n_fail++; $display("FAIL ch5_high_clocks actual=%0d expected=24", c5);
        end
    endtask

    task automatic test_boundary_write();
        int n, hi4;
        int cnts [CH];
        int exp_cnt [CH];
        exp_cnt = '{12, 0, 4, 9, 3, 8};
        prescale = 4'd0;
        wait_ps(200, n);
        n_cmp++;
        if (n < 0) begin
            n_fail++; $display("FAIL bw_boundary_timeout clocks=%0d expected<=200", n);
        end
        idle(15);
        step(1'b1, 3'd4, 4'd3, 1'b0, '0);
        n_cmp++;
        if (period_start !== 1'b1) begin
            n_fail++; $display("FAIL write_on_boundary_align actual=%b expected=1", period_start);
        end
        hi4 = 0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 1)      step(1'b1, 3'd7, 4'd15, 1'b0, '0);
            else if (i == 2) step(1'b1, 3'd6, 4'd15, 1'b0, '0);
            else             step(1'b0, '0, '0, 1'b0, '0);
            hi4 += int'(pwm_out[4]);
        end
        n_cmp++;
        if (hi4 !== 3) begin
            n_fail++; $display("FAIL bypass_ch4_high actual=%0d expected=3", hi4);
        end
        for (int c = 0; c < CH; c++) cnts[c] = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            for (int c = 0; c < CH; c++) cnts[c] += int'(pwm_out[c]);
        end
        for (int c = 0; c < CH; c++) begin
            n_cmp++;
            if (cnts[c] !== exp_cnt[c]) begin
                n_fail++; $display("FAIL level_after_bad_addr ch%0d actual=%0d expected=%0d", c, cnts[c], exp_cnt[c]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [CH-1:0] any_on;
        int first_ps;
        idle(11);
        n_cmp++;
        if (pwm_out[0] !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_ch0 actual=%b expected=1", pwm_out[0]);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pwm_out !== 6'h00) begin
            n_fail++; $display("FAIL async_reset_pwm actual=%h expected=00", pwm_out);
        end
        n_cmp++;
        if (period_start !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_ps actual=%b expected=0", period_start);
        end
        @(negedge clk);
        rst = 1'b0;
        any_on = '0;
        first_ps = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, '0, '0, 1'b0, '0);
            any_on |= pwm_out;
            if (period_start === 1'b1 && first_ps < 0) first_ps = i;
        end
        n_cmp++;
        if (any_on !== '0) begin
            n_fail++; $display("FAIL levels_cleared actual=%h expected=00", any_on);
        end
        n_cmp++;
        if (first_ps !== 16) begin
            n_fail++; $display("FAIL post_reset_period clocks=%0d expected=16", first_ps);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) prescale = PW'($urandom_range(0, 2));
            step($urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), W'($urandom),
                 $urandom_range(0, 15) == 0, W'($urandom_range(0, 15)));
            n_cmp++;
            if (pwm_out !== m_out) begin
                n_fail++; $display("FAIL random_pwm cycle=%0d actual=%h expected=%h", i, pwm_out, m_out);
            end
            n_cmp++;
            if (period_start !== m_ps) begin
                n_fail++; $display("FAIL random_period_start cycle=%0d actual=%b expected=%b", i, period_start, m_ps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level_wrap();
        test_top_period();
        test_prescale();
        test_boundary_write();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_multichannel_driver.md
Name: pwm_multichannel_driver

Overview:
Parametrised N-channel PWM generator; next generation of the 3-bit 8-channel PWM driver.
- Adds configurable resolution, channel count, prescaler and programmable period (top).
- Level and top writes are double-buffered and take effect only at a period boundary, so outputs are glitch-free.
- Sits between the tile's I/O decode logic and the pad outputs. The decode logic drives the write strobes.

Parameters:
CHANNELS, 8, number of PWM outputs (>=1)
WIDTH, 8, counter/level/top resolution in bits (>=2)
PRESCALE_W, 4, prescaler compare width
ADDR_W, $clog2(CHANNELS) (min 1), channel address width; localparam, derived

Ports:
clk  input  1  sole clock
rst  input  1  asynchronous, active-high reset
prescale  input  PRESCALE_W  tick every prescale+1 clk cycles; sampled live
lvl_wr_en  input  1  write strobe for a channel level
lvl_wr_addr  input  ADDR_W  target channel
lvl_wr_data  input  WIDTH  new duty level
top_wr_en  input  1  write strobe for period top
top_wr_data  input  WIDTH  new top value
pwm_out  output  CHANNELS  registered PWM outputs
period_start  output  1  one-cycle pulse when the counter wraps and shadows load

Behaviour:
Interface: one clock (clk); reset rst is asynchronous and active-high.

Reset (async, effective without a clock edge):
- prescaler count = 0, period counter cnt = 0.
- All shadow and active levels = 0.
- top shadow and active top = all ones.
- pwm_out = 0, period_start = 0.

Prescaler:
- pre_cnt increments each clk.
- tick = (pre_cnt == prescale); on tick, pre_cnt <= 0.
- prescale = 0 gives a tick every clk.
- If prescale is lowered below pre_cnt, pre_cnt wraps naturally at 2^PRESCALE_W. No special case.

Counter (sawtooth):
- On each tick: if cnt == active_top, then cnt <= 0 (boundary); otherwise cnt <= cnt + 1.
- Period = active_top + 1 ticks.

Boundary edge (tick && cnt == active_top):
- active_level[i] <= shadow_level[i] for all channels.
- active_top <= shadow_top.
- period_start <= 1 for exactly one clk; 0 otherwise.

Writes:
- lvl_wr_en writes shadow_level[lvl_wr_addr]; top_wr_en writes shadow_top. Both may occur in the same cycle.
- Address >= CHANNELS: write ignored, no other effect.
- Write on the boundary edge is bypassed: the active register loads the incoming write data, so it applies from the new period.

Output:
- pwm_out[i] <= (cnt < active_level[i]), registered; 1 clk latency after cnt.
- level 0 is always off.
- level > active_top is always on.
- active_top = 0 gives a 1-tick period; any level >= 1 is always on.

Optional Feature:
PWM_CENTER_ALIGNED_EN
- Defined:
  - Counter is a triangle: counts up 0..active_top, then down to 0. A direction register (reset = up) controls counting.
  - Period = 2*active_top ticks.
  - Boundary (shadow load, period_start) is the tick where cnt == 1 while counting down, i.e. cnt returns to 0.
  - active_top = 0 holds cnt at 0; boundary fires every tick.
  - Compare is unchanged, giving symmetric pulses.
- Undefined: sawtooth as above. The direction register is not instantiated.

Decomposition:
- Package pwm_pkg: default widths (WIDTH, PRESCALE_W), counter-mode enum {SAW, TRIANGLE}, compare function is_on(level, cnt).
- Sub-module pwm_channel: holds shadow/active level and registered compare output. Inputs are write enable, data, load strobe, cnt. Instantiated CHANNELS times by generate.
- Prescaler and counter stay in the top module.

Test Plan:
(CHANNELS=8, WIDTH=4, prescale=0, top=15 unless noted)
1. Reset release -> pwm_out=0x00, period_start low; first period_start 16 clk after reset deassert.
2. Write ch2=4 at cnt=7 -> pwm_out[2] stays 0 until wrap. Then high for 4 clk, low for 12 clk, repeating; other channels stay 0.
3. top=9 written, ch0=12, ch1=0, ch3=9 -> after next boundary, period=10 clk. out[0] always 1; out[1] always 0; out[3] high 9 of 10.
4. prescale=2, ch5=8 -> cnt advances every 3 clk; period 48 clk, out[5] high 24 clk. period_start pulse width is 1 clk.
5. lvl_wr_en on the exact boundary cycle (ch4=3) -> new level active in the immediately following period; write to addr 7 with CHANNELS=6 has no effect.
6. Assert rst mid-period (cnt=10, outputs high) -> pwm_out=0 asynchronously, before the next clk edge. After release, levels read back as 0 (all outputs off).
